deserializer: RTL and testbench
===============================

DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload width in bits, minimum 2.
REQ-002 SHALL have parameter HAS_ECC, default 0: when 1, CODE_BITS Hamming parity bits follow the payload on the line and are decoded.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port serial_in_i, input, 1: line data bit, MSB first.
REQ-006 SHALL have port enable_i, input, 1: serial_in_i holds a valid bit this cycle.
REQ-007 SHALL have port start_i, input, 1: marks the first bit of a word; meaningful only with enable_i.
REQ-008 SHALL have port parallel_out_o, output, DATA_WIDTH: received (corrected) word.
REQ-009 SHALL have port valid_out_o, output, 1: one-cycle pulse qualifying parallel_out_o.
REQ-010 SHALL have port ecc_corrected_o, output, 1: with valid_out_o, a single-bit error was corrected; tied 0 when HAS_ECC=0.
REQ-011 SHALL have port ecc_uncorrectable_o, output, 1: with valid_out_o, the decoder flagged an uncorrectable error; tied 0 when HAS_ECC=0.
REQ-012 SHALL have port framing_error_o, output, 1: one-cycle pulse when a word is aborted by a new start.

Function
REQ-013 SHALL define the line word length W = DATA_WIDTH, or DATA_WIDTH+CODE_BITS when HAS_ECC=1.
REQ-014 SHALL implement states IDLE and RECV, plus DECODE when HAS_ECC=1.
REQ-015 IDLE: enable_i&start_i SHALL load serial_in_i as bit W-1, set bit count 1 and go to RECV; any other input SHALL be ignored.
REQ-016 RECV: each enable_i&!start_i cycle SHALL shift serial_in_i in (data bits, then parity bits, each MSB first) and increment the count; enable_i low SHALL hold all state.
REQ-017 RECV: when the count reaches W, SHALL go to IDLE (HAS_ECC=0) or DECODE (HAS_ECC=1).
REQ-018 HAS_ECC=0: valid_out_o SHALL pulse the cycle after the W-th bit is sampled, with parallel_out_o equal to the shifted data.
REQ-019 HAS_ECC=1: DECODE SHALL present data and parity to the decoder for one cycle and go to IDLE; valid_out_o, ecc_corrected_o and ecc_uncorrectable_o SHALL pulse 2 cycles after the W-th bit is sampled.
REQ-020 parallel_out_o SHALL hold its last value between valid pulses.
REQ-021 enable_i&start_i in RECV SHALL pulse framing_error_o next cycle, discard the partial word (no valid_out_o), and restart as in REQ-015 with that bit.
REQ-022 A start in the cycle after the W-th bit, or in DECODE, SHALL begin a new word with no bit loss, and the pending output SHALL still be produced.
REQ-023 The bit counter SHALL be $clog2(W)+1 bits wide and SHALL never wrap within a word.

Reset
REQ-024 rst_n_i low SHALL immediately force IDLE, counter 0, shift registers 0, parallel_out_o 0, and all pulse outputs 0.
REQ-025 Reset mid-word SHALL discard the partial word; no valid_out_o or framing_error_o SHALL follow deassertion.

Structure
REQ-026 CODE_BITS and the W derivation SHALL come from gray_area_package / hamming_defines.svh, shared with the transmit side.
REQ-027 The state enum SHALL live in gray_area_package.
REQ-028 HAS_ECC=1 SHALL instantiate one sub-module, hamming_decode (DATA_WIDTH), inside a generate block; HAS_ECC=0 SHALL instantiate no decoder.

Verification
REQ-029 HAS_ECC=0, DATA_WIDTH=8: start+bits 1,0,1,0,0,1,0,1 -> valid_out_o pulses 1 cycle after the last bit, parallel_out_o=8'hA5.
REQ-030 HAS_ECC=0: enable_i dropped for 3 cycles after bit 4 of 8'h3C -> output 8'h3C, valid delayed by exactly 3 cycles.
REQ-031 HAS_ECC=0: new start after 5 bits of 8'hFF, then full 8'h12 -> framing_error_o pulse once, single valid with 8'h12.
REQ-032 HAS_ECC=1: encoded 8'h5A with data bit 3 flipped -> parallel_out_o=8'h5A, ecc_corrected_o=1; with two bits flipped -> ecc_uncorrectable_o=1.
REQ-033 Reset asserted after 4 bits, then full 8'hC3 -> no spurious valid, single valid with 8'hC3.
REQ-034 Loopback with serializer, both HAS_ECC values, 1000 random back-to-back words -> every word received in order, no framing errors.

Source files
------------

// File: rtl/gray_area_package.sv
// Shared definitions for the serial link: Hamming/SECDED sizing and the
// receive-side state encoding, used by both the transmit and receive ends.
package gray_area_package;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECV   = 2'd1,
      ST_DECODE = 2'd2
   } des_state_t;

   // Number of Hamming check bits r, the smallest r with 2^r >= dw + r + 1
   function automatic int hamming_r(input int dw);
      int r;
      r = 1;
      while ((1 << r) < dw + r + 1) r++;
      return r;
   endfunction

   // Hamming check bits plus one overall-parity bit (SECDED)
   function automatic int code_bits(input int dw);
      return hamming_r(dw) + 1;
   endfunction

   function automatic int line_width(input int dw, input int has_ecc);
      return (has_ecc != 0) ? dw + code_bits(dw) : dw;
   endfunction

endpackage

// File: rtl/hamming_decode.sv
// Combinational SECDED decoder: corrects any single-bit error and flags
// double-bit errors. parity[r] is the overall parity, parity[i] covers position 2^i.
module hamming_decode
   import gray_area_package::*;
#(
   parameter int DATA_WIDTH = 8
)(
   input  logic [DATA_WIDTH-1:0]            data,
   input  logic [code_bits(DATA_WIDTH)-1:0] parity,
   output logic [DATA_WIDTH-1:0]            fixed_data,
   output logic                             corrected,
   output logic                             uncorrectable
);

   localparam int R = hamming_r(DATA_WIDTH);
   localparam int N = DATA_WIDTH + R;

   logic [N:1]   code;
   logic [R-1:0] syndrome;
   logic         overall;
   logic         single;

   // Check bits sit at power-of-two positions, data fills the rest in ascending order
   for (genvar p = 1; p <= N; p++) begin : g_map
      if ((p & (p - 1)) == 0) begin : g_par
         assign code[p] = parity[$clog2(p)];
      end else begin : g_dat
         assign code[p] = data[p - $clog2(p + 1) - 1];
         assign fixed_data[p - $clog2(p + 1) - 1] =
            code[p] ^ (single && (syndrome == R'(p)));
      end
   end

   always_comb begin
      syndrome = '0;
      for (int p = 1; p <= N; p++) begin
         if (code[p]) syndrome = syndrome ^ R'(p);
      end
      overall = (^code) ^ parity[R];
   end

   // Odd overall parity means one flipped bit; syndrome 0 then points at the overall bit itself
   always_comb begin
      single        = overall && (int'(syndrome) <= N);
      corrected     = single;
      uncorrectable = (!overall && (syndrome != '0)) || (overall && (int'(syndrome) > N));
   end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel receiver, MSB first, with start framing and optional
// SECDED decoding of trailing parity bits.
module deserializer
   import gray_area_package::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int HAS_ECC    = 0
)(
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  serial_in_i,
   input  logic                  enable_i,
   input  logic                  start_i,
   output logic [DATA_WIDTH-1:0] parallel_out_o,
   output logic                  valid_out_o,
   output logic                  ecc_corrected_o,
   output logic                  ecc_uncorrectable_o,
   output logic                  framing_error_o
);

   localparam int W  = line_width(DATA_WIDTH, HAS_ECC);
   localparam int CW = $clog2(W) + 1;
   localparam int CB = code_bits(DATA_WIDTH);

   des_state_t      state, state_nxt;
   logic [CW-1:0]   count, count_nxt;
   logic [W-1:0]    shift, shift_nxt;
   logic            word_done;
   logic            abort;

   logic [DATA_WIDTH-1:0] dec_data;
   logic                  dec_corrected;
   logic                  dec_uncorrectable;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= ST_IDLE;
         count <= '0;
         shift <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         shift <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      shift_nxt = shift;
      word_done = 1'b0;
      abort     = 1'b0;
      unique case (state)
         ST_IDLE, ST_DECODE: begin
            // DECODE only reads the old word, so a new start here loses no bit
            if (enable_i && start_i) begin
               state_nxt          = ST_RECV;
               count_nxt          = CW'(1);
               shift_nxt          = '0;
               shift_nxt[W-1]     = serial_in_i;
            end else if (state == ST_DECODE) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_RECV: begin
            if (enable_i && start_i) begin
               abort          = 1'b1;
               count_nxt      = CW'(1);
               shift_nxt      = '0;
               shift_nxt[W-1] = serial_in_i;
            end else if (enable_i) begin
               shift_nxt[(W - 1) - int'(count)] = serial_in_i;
               count_nxt = count + CW'(1);
               if (count == CW'(W - 1)) begin
                  word_done = 1'b1;
                  state_nxt = (HAS_ECC != 0) ? ST_DECODE : ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   if (HAS_ECC != 0) begin : g_ecc
      hamming_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
         .data          (shift[W-1 -: DATA_WIDTH]),
         .parity        (shift[CB-1:0]),
         .fixed_data    (dec_data),
         .corrected     (dec_corrected),
         .uncorrectable (dec_uncorrectable)
      );
   end else begin : g_no_ecc
      assign dec_data          = '0;
      assign dec_corrected     = 1'b0;
      assign dec_uncorrectable = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         parallel_out_o      <= '0;
         valid_out_o         <= 1'b0;
         ecc_corrected_o     <= 1'b0;
         ecc_uncorrectable_o <= 1'b0;
         framing_error_o     <= 1'b0;
      end else begin
         valid_out_o         <= 1'b0;
         ecc_corrected_o     <= 1'b0;
         ecc_uncorrectable_o <= 1'b0;
         framing_error_o     <= abort;
         if ((HAS_ECC == 0) && word_done) begin
            valid_out_o    <= 1'b1;
            parallel_out_o <= shift_nxt[W-1 -: DATA_WIDTH];
         end
         if ((HAS_ECC != 0) && (state == ST_DECODE)) begin
            valid_out_o         <= 1'b1;
            parallel_out_o      <= dec_data;
            ecc_corrected_o     <= dec_corrected;
            ecc_uncorrectable_o <= dec_uncorrectable;
         end
      end
   end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: a plain instance (HAS_ECC=0) and a SECDED
// instance (HAS_ECC=1) share clock, reset and line, each with its own enable.
module tb_deserializer;

   logic clk = 1'b0;
   logic rst_n, sin, st, en0, en1;
   always #5 clk = ~clk;

   logic [7:0] out0, out1;
   logic       v0, c0, u0, f0, v1, c1, u1, f1;

   deserializer #(.DATA_WIDTH(8), .HAS_ECC(0)) dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .serial_in_i(sin), .enable_i(en0), .start_i(st),
      .parallel_out_o(out0), .valid_out_o(v0), .ecc_corrected_o(c0),
      .ecc_uncorrectable_o(u0), .framing_error_o(f0));

   deserializer #(.DATA_WIDTH(8), .HAS_ECC(1)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .serial_in_i(sin), .enable_i(en1), .start_i(st),
      .parallel_out_o(out1), .valid_out_o(v1), .ecc_corrected_o(c1),
      .ecc_uncorrectable_o(u1), .framing_error_o(f1));

   int checks = 0, failures = 0;
   int cyc = 0, last_edge = 0, start_edge = 0;
   int v0_n = 0, f0_n = 0, v1_n = 0, f1_n = 0, v0_cyc = 0, v1_cyc = 0, f0_cyc = 0, ecc0_n = 0;
   logic [7:0] q0[$];
   logic [9:0] q1[$];

   // Edge-numbered monitor sampling 1 time unit after each rising edge
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (v0) begin v0_n++; v0_cyc = cyc; q0.push_back(out0); end
      if (f0) begin f0_n++; f0_cyc = cyc; end
      if (c0 || u0) ecc0_n++;
      if (v1) begin v1_n++; v1_cyc = cyc; q1.push_back({c1, u1, out1}); end
      if (f1) f1_n++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pop0();
      if (q0.size() > 0) return q0.pop_front();
      return 8'hxx;
   endfunction

   function automatic logic [9:0] pop1();
      if (q1.size() > 0) return q1.pop_front();
      return 10'hxxx;
   endfunction

   task automatic bit0(input logic s, input logic b);
      @(negedge clk);
      st = s; sin = b; en0 = 1'b1; en1 = 1'b0;
      last_edge = cyc + 1;
      if (s) start_edge = cyc + 1;
   endtask

   task automatic bit1(input logic s, input logic b);
      @(negedge clk);
      st = s; sin = b; en0 = 1'b0; en1 = 1'b1;
      last_edge = cyc + 1;
      if (s) start_edge = cyc + 1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         st = 1'b0; sin = 1'b0; en0 = 1'b0; en1 = 1'b0;
      end
   endtask

   task automatic send0(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) bit0(i == 7, w[i]);
   endtask

   task automatic send1(input logic [12:0] w);
      for (int i = 12; i >= 0; i--) bit1(i == 12, w[i]);
   endtask

   initial begin
      int n0, nf;
      logic [7:0] w;
      logic [7:0] exp_q[$];
      logic [9:0] e1;

      rst_n = 1'b0; sin = 1'b0; st = 1'b0; en0 = 1'b0; en1 = 1'b0;
      #1;
      check("rst_out0", out0, 8'h00);
      check("rst_valid0", v0, 1'b0);
      check("rst_frame0", f0, 1'b0);
      check("rst_out1", out1, 8'h00);
      check("rst_flags1", {v1, c1, u1, f1}, 4'b0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // A5 with no gaps: valid right after the edge sampling bit 8
      n0 = v0_n;
      send0(8'hA5);
      idle(3);
      check("a5_count", v0_n - n0, 1);
      check("a5_data", pop0(), 8'hA5);
      check("a5_latency", v0_cyc - start_edge, 7);
      check("a5_hold", out0, 8'hA5);

      // 3C with enable low for 3 cycles after bit 4
      n0 = v0_n;
      for (int i = 7; i >= 4; i--) bit0(i == 7, w[0] ^ w[0] ^ 8'h3C >> i);
      idle(3);
      check("gap_novalid", v0_n - n0, 0);
      for (int i = 3; i >= 0; i--) bit0(1'b0, 8'h3C >> i);
      idle(3);
      check("gap_count", v0_n - n0, 1);
      check("gap_data", pop0(), 8'h3C);
      check("gap_latency", v0_cyc - start_edge, 10);

      // Five bits of FF aborted by a new start, then a full 12
      n0 = v0_n; nf = f0_n;
      bit0(1'b1, 1'b1);
      repeat (4) bit0(1'b0, 1'b1);
      send0(8'h12);
      idle(3);
      check("frame_pulses", f0_n - nf, 1);
      check("frame_when", f0_cyc, start_edge);
      check("frame_valids", v0_n - n0, 1);
      check("frame_data", pop0(), 8'h12);

      // Back-to-back words: start in the cycle right after the last bit
      n0 = v0_n;
      send0(8'h81);
      send0(8'h7E);
      idle(3);
      check("b2b_count", v0_n - n0, 2);
      check("b2b_first", pop0(), 8'h81);
      check("b2b_second", pop0(), 8'h7E);

      // Reset after four bits of C3, then a full C3
      n0 = v0_n; nf = f0_n;
      for (int i = 7; i >= 4; i--) bit0(i == 7, 8'hC3 >> i);
      @(negedge clk);
      rst_n = 1'b0; en0 = 1'b0; st = 1'b0;
      #1;
      check("midrst_out", out0, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      check("midrst_novalid", v0_n - n0, 0);
      send0(8'hC3);
      idle(3);
      check("midrst_count", v0_n - n0, 1);
      check("midrst_data", pop0(), 8'hC3);
      check("midrst_noframe", f0_n - nf, 0);

      // Random back-to-back stream
      n0 = v0_n; nf = f0_n;
      for (int k = 0; k < 16; k++) begin
         w = 8'($urandom);
         exp_q.push_back(w);
         send0(w);
      end
      idle(3);
      check("rand_count", v0_n - n0, 16);
      for (int k = 0; k < 16; k++) check($sformatf("rand_word%0d", k), pop0(), exp_q[k]);
      check("rand_noframe", f0_n - nf, 0);
      check("noecc_flags", ecc0_n, 0);

      // SECDED: 5A encodes with parity 00000, 01 with parity 10011
      n0 = v1_n;
      send1({8'h5A, 5'b00000});
      idle(4);
      check("ecc_clean_count", v1_n - n0, 1);
      check("ecc_clean", pop1(), {2'b00, 8'h5A});
      check("ecc_latency", v1_cyc - start_edge, 13);

      send1({8'h52, 5'b00000});
      idle(4);
      check("ecc_fix_d3", pop1(), {2'b10, 8'h5A});

      send1({8'h53, 5'b00000});
      idle(4);
      e1 = pop1();
      check("ecc_double", e1[9:8], 2'b01);

      send1({8'h01, 5'b10011});
      idle(4);
      check("ecc_clean01", pop1(), {2'b00, 8'h01});

      send1({8'h01, 5'b00011});
      idle(4);
      check("ecc_fix_overall", pop1(), {2'b10, 8'h01});

      // Start while the previous word is in DECODE
      n0 = v1_n;
      send1({8'h5A, 5'b00000});
      send1({8'h52, 5'b00000});
      idle(4);
      check("ecc_b2b_count", v1_n - n0, 2);
      check("ecc_b2b_first", pop1(), {2'b00, 8'h5A});
      check("ecc_b2b_second", pop1(), {2'b10, 8'h5A});
      check("ecc_noframe", f1_n, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
